// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - FSM state encoding (3 bits; 4 bits when the tag states are built)
//   - TAG_NIBBLE: upper nibble of the per-grant tag byte
//   - next_ptr(): round-robin pointer advance modulo the requester count
// Optional feature macro: UART_TX_ARB_TAG_EN adds the tag states.
package uart_ctrl_pkg;

  localparam int IDX_W = 3;
  localparam logic [3:0] TAG_NIBBLE = 4'hA;

`ifdef UART_TX_ARB_TAG_EN
  localparam int ST_W = 4;
`else
  localparam int ST_W = 3;
`endif

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = ST_W'(0),
    ST_ARB       = ST_W'(1),
    ST_LOAD      = ST_W'(2),
    ST_WAIT_ACT  = ST_W'(3),
    ST_WAIT_DONE = ST_W'(4),
    ST_GAP       = ST_W'(5)
`ifdef UART_TX_ARB_TAG_EN
    ,
    ST_TAG_LOAD      = ST_W'(6),
    ST_TAG_WAIT_ACT  = ST_W'(7),
    ST_TAG_WAIT_DONE = ST_W'(8),
    ST_TAG_GAP       = ST_W'(9)
`endif
  } state_t;

  // Index following idx, wrapping to 0 after the last requester.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                input int num_req);
    logic [IDX_W-1:0] nxt_s;
    if (int'(idx) + 1 >= num_req) begin
      nxt_s = '0;
    end else begin
      nxt_s = idx + IDX_W'(1);
    end
    return nxt_s;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot of the first requester at or after ptr (wrapping)
//   idx   : binary index of grant
//   any   : at least one request present
// Optional feature macro UART_TX_ARB_TAG_EN has no effect on this module.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Rotating a doubled copy puts the pointer's requester at bit 0.
  logic [2*NUM_REQ-1:0] dbl_s;
  logic                 found_s;

  assign dbl_s = {req, req} >> ptr;

  // Find the first set bit of the rotated vector and map it back to an index.
  always_comb begin
    int pos_s;
    idx     = '0;
    found_s = 1'b0;
    pos_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s   = int'(ptr) + k;
      pos_s   = (pos_s >= NUM_REQ) ? (pos_s - NUM_REQ) : pos_s;
      idx     = (dbl_s[k] && !found_s) ? IDX_W'(pos_s) : idx;
      found_s = found_s | dbl_s[k];
    end
  end

  assign any   = |req;
  assign grant = any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART transmitter among
// NUM_REQ byte-stream requesters. A grant lasts until the message's last
// byte or MAX_BURST bytes, then rotates.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_req/in_req_byte/in_req_last   per-requester byte offer (bytes flattened)
//   out_req_ack           one-cycle pulse when a requester's byte is taken
//   out_grant             one-hot current owner, 0 when idle
//   out_tx_data_valid/out_tx_byte    load strobe and byte to the transmitter
//   in_tx_active/in_tx_complete      transmitter busy / frame-done status
//   out_timeout           sticky: transmitter never went active after a load
// Optional feature macro UART_TX_ARB_TAG_EN: each grant is preceded by a tag
// byte {TAG_NIBBLE, 1'b0, grant index}, not acked and not burst-counted.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   in_req,
  input  logic [8*NUM_REQ-1:0] in_req_byte,
  input  logic [NUM_REQ-1:0]   in_req_last,
  output logic [NUM_REQ-1:0]   out_req_ack,
  output logic [NUM_REQ-1:0]   out_grant,
  output logic                 out_tx_data_valid,
  output logic [7:0]           out_tx_byte,
  input  logic                 in_tx_active,
  input  logic                 in_tx_complete,
  output logic                 out_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TIMEOUT_C   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]      MAX_BURST_C = 8'(MAX_BURST);

`ifdef UART_TX_ARB_TAG_EN
  localparam state_t FIRST_LOAD_ST = ST_TAG_LOAD;
`else
  localparam state_t FIRST_LOAD_ST = ST_LOAD;
`endif

  state_t             state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [7:0]         burst_r;
  logic               last_q_r;
  logic [TO_W-1:0]    to_cnt_r;
  logic [7:0]         tx_byte_r;
  logic               tx_valid_r;
  logic [NUM_REQ-1:0] ack_r;
  logic               timeout_r;

  logic [NUM_REQ-1:0] arb_grant_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               arb_any_s;
  logic [7:0]         sel_byte_s;
  logic               sel_last_s;
  logic               sel_req_s;
  logic [7:0]         burst_inc_s;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (in_req),
    .ptr  (ptr_r),
    .grant(arb_grant_s),
    .idx  (arb_idx_s),
    .any  (arb_any_s)
  );

  // Granted requester's byte/last/req, and the saturating burst increment.
  always_comb begin
    sel_byte_s = 8'd0;
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_byte_s = sel_byte_s | (in_req_byte[i*8 +: 8] & {8{grant_r[i]}});
      sel_last_s = sel_last_s | (in_req_last[i] & grant_r[i]);
    end
    sel_req_s   = |(in_req & grant_r);
    burst_inc_s = (burst_r == 8'hFF) ? 8'hFF : (burst_r + 8'd1);
  end

  // Scheduler FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      grant_r     <= '0;
      grant_idx_r <= '0;
      ptr_r       <= '0;
      burst_r     <= 8'd0;
      last_q_r    <= 1'b0;
      to_cnt_r    <= '0;
      tx_byte_r   <= 8'd0;
      tx_valid_r  <= 1'b0;
      ack_r       <= '0;
      timeout_r   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      tx_valid_r <= 1'b0;
      ack_r      <= '0;
      case (state_r)
        ST_IDLE: begin
          state_r <= (|in_req) ? ST_ARB : ST_IDLE;
        end
        ST_ARB: begin
          if (arb_any_s) begin
            grant_r     <= arb_grant_s;
            grant_idx_r <= arb_idx_s;
            burst_r     <= 8'd0;
            state_r     <= FIRST_LOAD_ST;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (sel_req_s) begin
            tx_byte_r  <= sel_byte_s;
            tx_valid_r <= 1'b1;
            ack_r      <= grant_r;
            last_q_r   <= sel_last_s;
            to_cnt_r   <= TO_W'(1);
            state_r    <= ST_WAIT_ACT;
          end else begin
            // Requester withdrew: hand the turn on.
            grant_r <= '0;
            ptr_r   <= next_ptr(grant_idx_r, NUM_REQ);
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT_ACT: begin
          if (in_tx_active) begin
            state_r <= ST_WAIT_DONE;
          end else if (to_cnt_r >= TIMEOUT_C) begin
            timeout_r <= 1'b1;
            grant_r   <= '0;
            ptr_r     <= next_ptr(grant_idx_r, NUM_REQ);
            state_r   <= ST_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          state_r <= in_tx_complete ? ST_GAP : ST_WAIT_DONE;
        end
        ST_GAP: begin
          // Loading again before complete drops would be missed by the transmitter.
          if (!in_tx_complete) begin
            burst_r <= burst_inc_s;
            if (last_q_r || (burst_inc_s == MAX_BURST_C)) begin
              grant_r <= '0;
              ptr_r   <= next_ptr(grant_idx_r, NUM_REQ);
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_LOAD;
            end
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        ST_TAG_LOAD: begin
          tx_byte_r  <= {TAG_NIBBLE, 1'b0, grant_idx_r};
          tx_valid_r <= 1'b1;
          to_cnt_r   <= TO_W'(1);
          state_r    <= ST_TAG_WAIT_ACT;
        end
        ST_TAG_WAIT_ACT: begin
          if (in_tx_active) begin
            state_r <= ST_TAG_WAIT_DONE;
          end else if (to_cnt_r >= TIMEOUT_C) begin
            timeout_r <= 1'b1;
            grant_r   <= '0;
            ptr_r     <= next_ptr(grant_idx_r, NUM_REQ);
            state_r   <= ST_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        ST_TAG_WAIT_DONE: begin
          state_r <= in_tx_complete ? ST_TAG_GAP : ST_TAG_WAIT_DONE;
        end
        ST_TAG_GAP: begin
          state_r <= in_tx_complete ? ST_TAG_GAP : ST_LOAD;
        end
`endif
        default: begin
          grant_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_req_ack       = ack_r;
  assign out_grant         = grant_r;
  assign out_tx_data_valid = tx_valid_r;
  assign out_tx_byte       = tx_byte_r;
  assign out_timeout       = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=3, TIMEOUT_CYCLES=16)
// driving a behavioural 8N1 transmitter (4 clocks per bit, complete high for
// 2 cycles). With UART_TX_ARB_TAG_EN the expected serial stream gains a tag
// byte per grant.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   in_req;
  logic [8*NR-1:0] in_req_byte;
  logic [NR-1:0]   in_req_last;
  logic [NR-1:0]   out_req_ack;
  logic [NR-1:0]   out_grant;
  logic            out_tx_data_valid;
  logic [7:0]      out_tx_byte;
  logic            tx_active;
  logic            tx_complete;
  logic            out_timeout;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(3), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_req           (in_req),
    .in_req_byte      (in_req_byte),
    .in_req_last      (in_req_last),
    .out_req_ack      (out_req_ack),
    .out_grant        (out_grant),
    .out_tx_data_valid(out_tx_data_valid),
    .out_tx_byte      (out_tx_byte),
    .in_tx_active     (tx_active),
    .in_tx_complete   (tx_complete),
    .out_timeout      (out_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [8:0]  rq_q [NR][$];   // {last, byte} per requester
  logic [10:0] ack_q[$];       // {idx, byte} seen with each ack
  logic [10:0] exp_ack_q[$];
  logic [7:0]  rx_q[$];        // bytes decoded from the serial line
  logic [7:0]  exp_rx_q[$];

  int   req_rise_cyc = 0;
  int   first_val_cyc = -1;
  int   to_cyc = -1;
  int   val_cnt = 0;
  int   ack_valid_cnt = 0;
  int   viol_cnt = 0;
  int   frm_err = 0;
  logic to_prev = 1'b0;
  logic [9:0] last_frm = 10'd0;

  logic       stall = 1'b0;
  logic       v_s = 1'b0;
  logic [7:0] b_s = 8'd0;
  logic       tx_serial;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh2idx(input logic [NR-1:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < NR; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  task automatic clear_logs();
    ack_q.delete(); exp_ack_q.delete(); rx_q.delete(); exp_rx_q.delete();
    first_val_cyc = -1; to_cyc = -1; ack_valid_cnt = 0;
  endtask

  task automatic push_exp(input logic [2:0] idx, input logic [7:0] b, input bit first);
    exp_ack_q.push_back({idx, b});
`ifdef UART_TX_ARB_TAG_EN
    if (first) exp_rx_q.push_back({4'hA, 1'b0, idx});
`endif
    exp_rx_q.push_back(b);
  endtask

  task automatic cmp_logs(input string name);
    check_value({name, "_ack_n"}, ack_q.size(), exp_ack_q.size());
    for (int k = 0; k < ack_q.size() && k < exp_ack_q.size(); k++)
      check_value($sformatf("%s_ack%0d", name, k), 32'(ack_q[k]), 32'(exp_ack_q[k]));
    check_value({name, "_rx_n"}, rx_q.size(), exp_rx_q.size());
    for (int k = 0; k < rx_q.size() && k < exp_rx_q.size(); k++)
      check_value($sformatf("%s_rx%0d", name, k), 32'(rx_q[k]), 32'(exp_rx_q[k]));
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (rq_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(all_empty() && out_grant == '0 && !tx_active && !tx_complete) && n < 3000);
    check_value(tag, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: offer queue heads, pop on ack.
  initial begin
    in_req = '0; in_req_byte = '0; in_req_last = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (out_req_ack[i] && rq_q[i].size() > 0) void'(rq_q[i].pop_front());
        if (rq_q[i].size() > 0) begin
          if (!in_req[i]) req_rise_cyc = cyc;
          in_req[i] = 1'b1;
          in_req_byte[i*8 +: 8] = rq_q[i][0][7:0];
          in_req_last[i] = rq_q[i][0][8];
        end else begin
          in_req[i] = 1'b0;
        end
      end
    end
  end

  // Behavioural transmitter: starts on the valid seen in the previous cycle.
  initial begin
    logic [9:0] sh;
    int ccnt, nb, cc;
    tx_active = 1'b0; tx_complete = 1'b0; tx_serial = 1'b1;
    sh = 10'h3FF; ccnt = 0; nb = 0; cc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_active = 1'b0; tx_complete = 1'b0; tx_serial = 1'b1; cc = 0;
      end else begin
        if (tx_complete) begin
          cc--;
          if (cc == 0) tx_complete = 1'b0;
        end
        if (tx_active) begin
          ccnt++;
          if (ccnt == 4) begin
            ccnt = 0; nb++;
            if (nb == 10) begin
              tx_active = 1'b0; tx_serial = 1'b1; tx_complete = 1'b1; cc = 2;
            end else begin
              sh = sh >> 1; tx_serial = sh[0];
            end
          end
        end else if (v_s && !stall) begin
          sh = {1'b1, b_s, 1'b0}; tx_active = 1'b1; tx_serial = 1'b0; ccnt = 0; nb = 0;
        end
      end
    end
  end

  // Monitor on the falling edge: strobes, acks, timeout edge, serial frames.
  initial begin
    logic [9:0] frm;
    int mc, fb;
    bit in_frm;
    frm = 10'd0; mc = 0; fb = 0; in_frm = 1'b0;
    forever begin
      @(negedge clk);
      v_s = out_tx_data_valid;
      b_s = out_tx_byte;
      if (out_tx_data_valid) begin
        val_cnt++;
        if (first_val_cyc < 0) first_val_cyc = cyc;
        if (tx_active) viol_cnt++;
        if (out_req_ack != '0) ack_valid_cnt++;
      end
      if (out_req_ack != '0) ack_q.push_back({oh2idx(out_req_ack), out_tx_byte});
      if (out_timeout && !to_prev) to_cyc = cyc;
      to_prev = out_timeout;
      if (!rst_n) begin
        in_frm = 1'b0;
      end else if (tx_active) begin
        if (!in_frm) begin in_frm = 1'b1; mc = 0; fb = 0; end
        if (mc % 4 == 1 && fb < 10) begin frm[fb] = tx_serial; fb++; end
        mc++;
      end else if (in_frm) begin
        in_frm = 1'b0;
        last_frm = frm;
        if (fb != 10 || frm[0] != 1'b0 || frm[9] != 1'b1) frm_err++;
        rx_q.push_back(frm[8:1]);
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    check_value({name, "_grant"}, 32'(out_grant), 32'd0);
    check_value({name, "_valid"}, 32'(out_tx_data_valid), 32'd0);
    check_value({name, "_ack"}, 32'(out_req_ack), 32'd0);
    check_value({name, "_byte"}, 32'(out_tx_byte), 32'd0);
    check_value({name, "_timeout"}, 32'(out_timeout), 32'd0);
  endtask

  initial begin
    int n, vc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0x55 from requester 0.
    clear_logs();
    rq_q[0].push_back({1'b1, 8'h55});
    push_exp(3'd0, 8'h55, 1'b1);
    wait_idle("t1_idle");
    // Counted from the clock edge that first samples in_req.
    check_value("t1_latency", 32'(first_val_cyc - req_rise_cyc - 1), 32'd2);
    check_value("t1_frame", 32'(last_frm), 32'h2AA);
    check_value("t1_ack_with_valid", 32'(ack_valid_cnt), 32'd1);
    check_value("t1_grant", 32'(out_grant), 32'd0);
    cmp_logs("t1");

    // Contention: requesters 1 and 2, three bytes each, same cycle.
    clear_logs();
    rq_q[1].push_back({1'b0, 8'h10}); rq_q[1].push_back({1'b0, 8'h11}); rq_q[1].push_back({1'b1, 8'h12});
    rq_q[2].push_back({1'b0, 8'h20}); rq_q[2].push_back({1'b0, 8'h21}); rq_q[2].push_back({1'b1, 8'h22});
    push_exp(3'd1, 8'h10, 1'b1); push_exp(3'd1, 8'h11, 1'b0); push_exp(3'd1, 8'h12, 1'b0);
    push_exp(3'd2, 8'h20, 1'b1); push_exp(3'd2, 8'h21, 1'b0); push_exp(3'd2, 8'h22, 1'b0);
    wait_idle("t2_idle");
    cmp_logs("t2");

    // Reset while requester 1's frame is on the line.
    rq_q[1].push_back({1'b1, 8'h5A});
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_active && n < 500);
    check_value("t3_active_seen", 32'(n < 500), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("t3_rst");
    for (int i = 0; i < NR; i++) rq_q[i].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    // Pointer back at 0: requester 2 must win over requester 3.
    rq_q[2].push_back({1'b1, 8'hC3});
    rq_q[3].push_back({1'b1, 8'h3C});
    push_exp(3'd2, 8'hC3, 1'b1);
    push_exp(3'd3, 8'h3C, 1'b1);
    wait_idle("t3_idle");
    cmp_logs("t3");

    // Burst limit 3: requester 0 streams six bytes, requester 3 one.
    clear_logs();
    for (int k = 1; k <= 6; k++) rq_q[0].push_back({1'b0, 8'(k)});
    rq_q[3].push_back({1'b1, 8'h33});
    push_exp(3'd0, 8'h01, 1'b1); push_exp(3'd0, 8'h02, 1'b0); push_exp(3'd0, 8'h03, 1'b0);
    push_exp(3'd3, 8'h33, 1'b1);
    push_exp(3'd0, 8'h04, 1'b1); push_exp(3'd0, 8'h05, 1'b0); push_exp(3'd0, 8'h06, 1'b0);
    wait_idle("t4_idle");
    cmp_logs("t4");
    check_value("t4_no_timeout", 32'(out_timeout), 32'd0);

    // Timeout: transmitter never becomes active.
    clear_logs();
    stall = 1'b1;
    rq_q[1].push_back({1'b1, 8'h77});
    n = 0;
    do begin @(negedge clk); n++; end while (!out_timeout && n < 500);
    check_value("t5_timeout_seen", 32'(n < 500), 32'd1);
    rq_q[1].delete();
    check_value("t5_delay", 32'(to_cyc - first_val_cyc), 32'd16);
    repeat (3) @(negedge clk);
    check_value("t5_grant", 32'(out_grant), 32'd0);
    vc = val_cnt;
    repeat (60) @(negedge clk);
    check_value("t5_no_revalid", 32'(val_cnt), 32'(vc));
    check_value("t5_sticky", 32'(out_timeout), 32'd1);

    check_value("valid_while_active", 32'(viol_cnt), 32'd0);
    check_value("frame_errors", 32'(frm_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
